// File: rtl/uart_alu_if_pkg.sv
// Shared definitions for the UART <-> ALU host endpoint:
// FSM state encoding and the opcode set understood by the ALU.
package uart_alu_if_pkg;

  // Frame sequencing states. SEND_CK is only reachable when the
  // checksum byte is built in.
  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    SEND_CK = 3'd5
  } state_t;

  // ALU opcodes (MIPS funct-style encoding)
  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] XOR = 6'h26;
  localparam logic [5:0] NOR = 6'h27;
  localparam logic [5:0] SRA = 6'h03;
  localparam logic [5:0] SRL = 6'h02;

endpackage

// File: rtl/uart_alu_if.sv
// Host-side UART endpoint: pops a 3-byte frame (A, B, opcode) from the
// receive FIFO, presents the fields to an external ALU, captures the
// result and pushes it to the transmit FIFO.
// Optional: define UART_ALU_IF_CHKSUM_EN to follow each result byte with
// a checksum byte (A ^ B ^ op ^ result).
module uart_alu_if
  import uart_alu_if_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_res,
  output logic            busy,
  output logic [7:0]      frame_cnt
);

  state_t          state, state_nxt;
  logic [DBIT-1:0] res_q;
`ifdef UART_ALU_IF_CHKSUM_EN
  logic [DBIT-1:0] chk_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= GET_A;
    else       state <= state_nxt;
  end

  // Next-state and FIFO handshakes; each handshake only fires when the
  // state owns it and the FIFO allows it.
  always_comb begin
    state_nxt = state;
    rd_uart   = 1'b0;
    wr_uart   = 1'b0;
    case (state)
      GET_A: if (!rx_empty) begin
        rd_uart   = 1'b1;
        state_nxt = GET_B;
      end
      GET_B: if (!rx_empty) begin
        rd_uart   = 1'b1;
        state_nxt = GET_OP;
      end
      GET_OP: if (!rx_empty) begin
        rd_uart   = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = SEND;
      SEND: if (!tx_full) begin
        wr_uart   = 1'b1;
`ifdef UART_ALU_IF_CHKSUM_EN
        state_nxt = SEND_CK;
`else
        state_nxt = GET_A;
`endif
      end
`ifdef UART_ALU_IF_CHKSUM_EN
      SEND_CK: if (!tx_full) begin
        wr_uart   = 1'b1;
        state_nxt = GET_A;
      end
`endif
      default: state_nxt = GET_A;
    endcase
    // No FIFO traffic while reset is held
    if (reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
    end
  end

  // Operand/result capture and completed-frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_q     <= '0;
      frame_cnt <= '0;
`ifdef UART_ALU_IF_CHKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      if (rd_uart && state == GET_A)  alu_a  <= r_data;
      if (rd_uart && state == GET_B)  alu_b  <= r_data;
      if (rd_uart && state == GET_OP) alu_op <= r_data[OP_W-1:0];
      if (state == EXEC) begin
        res_q <= alu_res;
`ifdef UART_ALU_IF_CHKSUM_EN
        chk_q <= alu_a ^ alu_b ^ DBIT'(alu_op) ^ alu_res;
`endif
      end
`ifdef UART_ALU_IF_CHKSUM_EN
      if (wr_uart && state == SEND_CK) frame_cnt <= frame_cnt + 8'd1;
`else
      if (wr_uart) frame_cnt <= frame_cnt + 8'd1;
`endif
    end
  end

  // Transmit byte always comes straight from a register so it is stable
  // across a tx_full stall.
`ifdef UART_ALU_IF_CHKSUM_EN
  assign w_data = (state == SEND_CK) ? chk_q : res_q;
`else
  assign w_data = res_q;
`endif

  assign busy = (state != GET_A);

endmodule

// File: tb/tb_uart_alu_if.sv
// Self-checking bench for uart_alu_if: FIFO models on both sides, a
// behavioural ALU, and a frame-level reference model checked every cycle.
module tb_uart_alu_if;
  import uart_alu_if_pkg::*;

  localparam int DBIT = 8;
  localparam int OP_W = 6;
`ifdef UART_ALU_IF_CHKSUM_EN
  localparam int NOUT = 2;
`else
  localparam int NOUT = 1;
`endif

  logic            clk = 0;
  logic            reset = 1;
  logic            rx_empty = 1;
  logic [DBIT-1:0] r_data = '0;
  logic            rd_uart;
  logic            tx_full = 0;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [DBIT-1:0] alu_a, alu_b;
  logic [OP_W-1:0] alu_op;
  logic [DBIT-1:0] alu_res;
  logic            busy;
  logic [7:0]      frame_cnt;

  uart_alu_if #(.DBIT(DBIT), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural ALU
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      ADD: return a + b;
      SUB: return a - b;
      AND: return a & b;
      OR:  return a | b;
      XOR: return a ^ b;
      NOR: return ~(a | b);
      SRA: return $signed(a) >>> b[2:0];
      SRL: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_res = alu(alu_a, alu_b, alu_op);

  // FIFO side / reference model state
  logic [7:0] rxq[$];
  logic [7:0] cur[$];      // bytes of the frame popped so far
  logic [7:0] expq[$];     // bytes still owed to the transmit FIFO
  logic [7:0] fa, fb;
  logic [5:0] fo;
  logic [7:0] outlog[$];
  logic       exec_pend = 0;
  logic       pop_req = 0;
  logic       rnd_full = 0;
  int         mcnt = 0;
  int         npush = 0;
  int         npop = 0;

  function automatic void upd_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endfunction

  // Compare process: whatever the FSM does internally, a pop is due
  // exactly when nothing is owed to the host and data is waiting, and a
  // push is due when a result is owed, the compute cycle has passed and
  // the transmit FIFO has room.
  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      expq.delete();
      exec_pend = 0;
      mcnt = 0;
    end else begin
      chk("rd_uart", rd_uart, (expq.size() == 0) && !rx_empty);
      chk("wr_uart", wr_uart, (expq.size() != 0) && !exec_pend && !tx_full);
      chk("busy", busy, (cur.size() != 0) || (expq.size() != 0));
      chk("frame_cnt", frame_cnt, mcnt[7:0]);
      exec_pend = 0;
      if (wr_uart && expq.size() != 0) begin
        chk("w_data", w_data, expq[0]);
        if (expq.size() == NOUT) begin
          chk("alu_a", alu_a, fa);
          chk("alu_b", alu_b, fb);
          chk("alu_op", alu_op, fo);
        end
        if (expq.size() == 1) mcnt++;
        outlog.push_back(w_data);
        npush++;
        void'(expq.pop_front());
      end
      if (rd_uart) begin
        pop_req = 1;
        npop++;
        cur.push_back(r_data);
        if (cur.size() == 3) begin
          fa = cur[0];
          fb = cur[1];
          fo = cur[2][5:0];
          expq.push_back(alu(fa, fb, fo));
`ifdef UART_ALU_IF_CHKSUM_EN
          expq.push_back(fa ^ fb ^ {2'b00, fo} ^ alu(fa, fb, fo));
`endif
          exec_pend = 1;
          cur.delete();
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pop_req) begin
        void'(rxq.pop_front());
        pop_req = 0;
      end
      if (rnd_full) tx_full = ($urandom_range(0, 3) == 0);
      upd_rx();
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    upd_rx();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((rxq.size() != 0 || cur.size() != 0 || expq.size() != 0) && c < maxc) begin
      tick();
      c++;
    end
    chk("drain_timeout", (c >= maxc), 0);
    tick(2);
  endtask

  logic [7:0] ops[8] = '{ADD, SUB, AND, OR, XOR, NOR, SRA, SRL};

  initial begin
    int base;
    logic [7:0] wd0;
    logic [7:0] hi;

    // Reset state
    tick(2);
    chk("rst_rd_uart", rd_uart, 0);
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    reset = 0;
    tick();

    // Single ADD frame
    base = npush;
    npop = 0;
    send3(8'h05, 8'h03, 8'h20);
    drain(50);
    chk("t1_pops", npop, 3);
    chk("t1_pushes", npush - base, NOUT);
    chk("t1_res", outlog[base], 8'h08);
`ifdef UART_ALU_IF_CHKSUM_EN
    chk("t1_chk", outlog[base+1], 8'h2E);
`endif
    chk("t1_a", alu_a, 8'h05);
    chk("t1_b", alu_b, 8'h03);
    chk("t1_op", alu_op, 6'h20);
    chk("t1_cnt", frame_cnt, 1);

    // Slow arrival, SUB
    base = npush;
    rxq.push_back(8'h0A); upd_rx(); tick(20);
    rxq.push_back(8'h04); upd_rx(); tick(20);
    rxq.push_back(8'h22); upd_rx();
    drain(50);
    chk("t2_res", outlog[base], 8'h06);
    chk("t2_cnt", frame_cnt, 2);

    // Transmit stall, OR
    base = npush;
    tx_full = 1;
    send3(8'h30, 8'h03, 8'h25);
    tick(5);
    wd0 = w_data;
    tick(10);
    chk("t3_stall_nopush", npush - base, 0);
    chk("t3_wdata_stable", w_data, wd0);
    chk("t3_wdata", w_data, 8'h33);
    tx_full = 0;
    drain(50);
    chk("t3_pushes", npush - base, NOUT);
    chk("t3_res", outlog[base], 8'h33);

    // Reset mid-frame
    rxq.push_back(8'h11); rxq.push_back(8'h22); upd_rx();
    tick(4);
    base = npush;
    reset = 1;
    tick();
    reset = 0;
    chk("t4_busy_after_rst", busy, 0);
    send3(8'h01, 8'h02, 8'h20);
    drain(50);
    chk("t4_pushes", npush - base, NOUT);
    chk("t4_res", outlog[base], 8'h03);
    chk("t4_cnt", frame_cnt, 1);

    // 256 back-to-back frames: counter wraps back to its start value
    base = npush;
    for (int i = 0; i < 256; i++) begin
      hi = 8'($urandom_range(0, 3)) << 6;
      send3(8'($urandom), 8'($urandom), hi | ops[$urandom_range(0, 7)]);
    end
    drain(5000);
    chk("t5_pushes", npush - base, 256 * NOUT);
    chk("t5_cnt_wrap", frame_cnt, 1);

    // Random gaps and transmit back-pressure
    rnd_full = 1;
    for (int i = 0; i < 60; i++) begin
      hi = 8'($urandom_range(0, 3)) << 6;
      rxq.push_back(8'($urandom));
      rxq.push_back(8'($urandom));
      rxq.push_back(hi | ops[$urandom_range(0, 7)]);
      upd_rx();
      tick($urandom_range(0, 8));
    end
    drain(5000);
    rnd_full = 0;
    tx_full = 0;
    tick(2);
    chk("t6_cnt", frame_cnt, (317 % 256));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
